// File: rtl/dp_sched_ctrl_pkg.sv
// Shared types and constants for the 6-step scheduled datapath controller:
// state encoding, operand-select codes, op codes and the control-word decode.
package dp_sched_ctrl_pkg;

  localparam int CODE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_S3   = 3'd3,
    ST_S4   = 3'd4,
    ST_S5   = 3'd5,
    ST_S6   = 3'd6,
    ST_S7   = 3'd7
  } state_e;

  localparam logic [CODE_W-1:0] SRC_I1    = 4'd0;
  localparam logic [CODE_W-1:0] SRC_I2    = 4'd1;
  localparam logic [CODE_W-1:0] SRC_I3    = 4'd2;
  localparam logic [CODE_W-1:0] SRC_I4    = 4'd3;
  localparam logic [CODE_W-1:0] SRC_I5    = 4'd4;
  localparam logic [CODE_W-1:0] SRC_I6    = 4'd5;
  localparam logic [CODE_W-1:0] SRC_MUL2  = 4'd6;
  localparam logic [CODE_W-1:0] SRC_MUL5  = 4'd7;
  localparam logic [CODE_W-1:0] SRC_ALU6  = 4'd8;
  localparam logic [CODE_W-1:0] SRC_MUL7  = 4'd9;
  localparam logic [CODE_W-1:0] SRC_MUL10 = 4'd10;
  localparam logic [CODE_W-1:0] SRC_LOG11 = 4'd11;
  localparam logic [CODE_W-1:0] SRC_ALU12 = 4'd12;

  localparam logic       ALU_ADD  = 1'b0;
  localparam logic       ALU_SUB  = 1'b1;
  localparam logic       MUL_MULT = 1'b0;
  localparam logic       MUL_DIV  = 1'b1;
  localparam logic [1:0] LOG_AND  = 2'b00;
  localparam logic [1:0] LOG_OR   = 2'b01;
  localparam logic [1:0] LOG_XOR  = 2'b10;

  typedef struct packed {
    logic [CODE_W-1:0] alu1_sel1;
    logic [CODE_W-1:0] alu1_sel2;
    logic [CODE_W-1:0] mul1_sel1;
    logic [CODE_W-1:0] mul1_sel2;
    logic [CODE_W-1:0] log1_sel1;
    logic [CODE_W-1:0] log1_sel2;
    logic              alu1_op;
    logic              mul1_op;
    logic [1:0]        log1_op;
    logic              reg_mul2_en;
    logic              reg_mul5_en;
    logic              reg_alu6_en;
    logic              reg_mul7_en;
    logic              reg_mul10_en;
    logic              reg_log11_en;
    logic              reg_alu12_en;
    logic              result_en;
    logic              done_next;
    logic              ready;
    logic              busy;
    logic [2:0]        step;
  } ctrl_t;

  // Moore decode: every field defaults to zero and each state overrides only its own controls.
  function automatic ctrl_t decode_state(input state_e st);
    ctrl_t c;
    c = '0;
    case (st)
      ST_IDLE: begin
        c.ready = 1'b1;
      end
      ST_S1: begin
        c.mul1_sel1 = SRC_I1;  c.mul1_sel2 = SRC_I2;  c.mul1_op = MUL_MULT;
        c.reg_mul2_en = 1'b1;
      end
      ST_S2: begin
        c.mul1_sel1 = SRC_I3;  c.mul1_sel2 = SRC_I4;  c.mul1_op = MUL_MULT;
        c.reg_mul5_en = 1'b1;
      end
      ST_S3: begin
        c.alu1_sel1 = SRC_MUL2; c.alu1_sel2 = SRC_MUL5; c.alu1_op = ALU_ADD;
        c.reg_alu6_en = 1'b1;
        c.mul1_sel1 = SRC_I5;  c.mul1_sel2 = SRC_I6;  c.mul1_op = MUL_MULT;
        c.reg_mul7_en = 1'b1;
      end
      ST_S4: begin
        c.mul1_sel1 = SRC_ALU6; c.mul1_sel2 = SRC_MUL7; c.mul1_op = MUL_MULT;
        c.reg_mul10_en = 1'b1;
      end
      ST_S5: begin
        c.log1_sel1 = SRC_MUL10; c.log1_sel2 = SRC_I1; c.log1_op = LOG_XOR;
        c.reg_log11_en = 1'b1;
      end
      ST_S6: begin
        c.alu1_sel1 = SRC_LOG11; c.alu1_sel2 = SRC_I2; c.alu1_op = ALU_SUB;
        c.reg_alu12_en = 1'b1;
      end
      ST_S7: begin
        c.result_en = 1'b1;
        c.done_next = 1'b1;
        c.ready     = 1'b1;
      end
      default: begin
        c.ready = 1'b1;
      end
    endcase
    if (st != ST_IDLE) begin
      c.busy = 1'b1;
      c.step = st;
    end else begin
      c.busy = 1'b0;
      c.step = 3'd0;
    end
    return c;
  endfunction

endpackage

// File: rtl/dp_sched_ctrl.sv
// Moore controller sequencing ((i1*i2 + i3*i4)*(i5*i6) ^ i1) - i2 over one ALU,
// one MUL/DIV and one LOGIC unit; the control word is registered alongside the state.
module dp_sched_ctrl
  import dp_sched_ctrl_pkg::*;
#(
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  output logic             busy,
  output logic [2:0]       step,
  output logic [SEL_W-1:0] alu1_sel1,
  output logic [SEL_W-1:0] alu1_sel2,
  output logic [SEL_W-1:0] mul1_sel1,
  output logic [SEL_W-1:0] mul1_sel2,
  output logic [SEL_W-1:0] log1_sel1,
  output logic [SEL_W-1:0] log1_sel2,
  output logic             alu1_op,
  output logic             mul1_op,
  output logic [1:0]       log1_op,
  output logic             reg_mul2_en,
  output logic             reg_mul5_en,
  output logic             reg_alu6_en,
  output logic             reg_mul7_en,
  output logic             reg_mul10_en,
  output logic             reg_log11_en,
  output logic             reg_alu12_en,
  output logic             result_en,
  output logic             done_next
);

  state_e state_r;
  state_e state_next_s;
  ctrl_t  ctrl_r;

  // Next-state rule: S7 re-enters S1 on start so back-to-back runs have no bubble.
  always_comb begin
    state_next_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_S1;
        else       state_next_s = ST_IDLE;
      end
      ST_S1:   state_next_s = ST_S2;
      ST_S2:   state_next_s = ST_S3;
      ST_S3:   state_next_s = ST_S4;
      ST_S4:   state_next_s = ST_S5;
      ST_S5:   state_next_s = ST_S6;
      ST_S6:   state_next_s = ST_S7;
      ST_S7: begin
        if (start) state_next_s = ST_S1;
        else       state_next_s = ST_IDLE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State plus its decoded control word, so outputs always match the current state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      ctrl_r  <= decode_state(ST_IDLE);
    end else begin
      state_r <= state_next_s;
      ctrl_r  <= decode_state(state_next_s);
    end
  end

  assign ready        = ctrl_r.ready;
  assign busy         = ctrl_r.busy;
  assign step         = ctrl_r.step;
  assign alu1_sel1    = SEL_W'(ctrl_r.alu1_sel1);
  assign alu1_sel2    = SEL_W'(ctrl_r.alu1_sel2);
  assign mul1_sel1    = SEL_W'(ctrl_r.mul1_sel1);
  assign mul1_sel2    = SEL_W'(ctrl_r.mul1_sel2);
  assign log1_sel1    = SEL_W'(ctrl_r.log1_sel1);
  assign log1_sel2    = SEL_W'(ctrl_r.log1_sel2);
  assign alu1_op      = ctrl_r.alu1_op;
  assign mul1_op      = ctrl_r.mul1_op;
  assign log1_op      = ctrl_r.log1_op;
  assign reg_mul2_en  = ctrl_r.reg_mul2_en;
  assign reg_mul5_en  = ctrl_r.reg_mul5_en;
  assign reg_alu6_en  = ctrl_r.reg_alu6_en;
  assign reg_mul7_en  = ctrl_r.reg_mul7_en;
  assign reg_mul10_en = ctrl_r.reg_mul10_en;
  assign reg_log11_en = ctrl_r.reg_log11_en;
  assign reg_alu12_en = ctrl_r.reg_alu12_en;
  assign result_en    = ctrl_r.result_en;
  assign done_next    = ctrl_r.done_next;

endmodule

// File: tb/tb_dp_sched_ctrl.sv
// Bench for dp_sched_ctrl: per-step decode table, a behavioural datapath driven by the
// controller's outputs, and the closed-form result as the reference for every run.
module tb_dp_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ready, busy;
  logic [2:0]  step;
  logic [3:0]  alu1_sel1, alu1_sel2, mul1_sel1, mul1_sel2, log1_sel1, log1_sel2;
  logic        alu1_op, mul1_op;
  logic [1:0]  log1_op;
  logic        reg_mul2_en, reg_mul5_en, reg_alu6_en, reg_mul7_en;
  logic        reg_mul10_en, reg_log11_en, reg_alu12_en;
  logic        result_en, done_next;

  dp_sched_ctrl #(.SEL_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .busy(busy), .step(step),
    .alu1_sel1(alu1_sel1), .alu1_sel2(alu1_sel2), .mul1_sel1(mul1_sel1),
    .mul1_sel2(mul1_sel2), .log1_sel1(log1_sel1), .log1_sel2(log1_sel2),
    .alu1_op(alu1_op), .mul1_op(mul1_op), .log1_op(log1_op),
    .reg_mul2_en(reg_mul2_en), .reg_mul5_en(reg_mul5_en), .reg_alu6_en(reg_alu6_en),
    .reg_mul7_en(reg_mul7_en), .reg_mul10_en(reg_mul10_en), .reg_log11_en(reg_log11_en),
    .reg_alu12_en(reg_alu12_en), .result_en(result_en), .done_next(done_next)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: operands, seven intermediates, result and done
  logic [31:0] i1, i2, i3, i4, i5, i6;
  logic [31:0] m_mul2, m_mul5, m_alu6, m_mul7, m_mul10, m_log11, m_alu12, m_result;
  logic        m_done;

  function automatic logic [31:0] src(input logic [3:0] sel);
    case (sel)
      4'd0: return i1;      4'd1: return i2;      4'd2: return i3;
      4'd3: return i4;      4'd4: return i5;      4'd5: return i6;
      4'd6: return m_mul2;  4'd7: return m_mul5;  4'd8: return m_alu6;
      4'd9: return m_mul7;  4'd10: return m_mul10; 4'd11: return m_log11;
      4'd12: return m_alu12;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic op);
    return op ? a - b : a + b;
  endfunction

  function automatic logic [31:0] mul_f(input logic [31:0] a, input logic [31:0] b, input logic op);
    if (op) return (b == 32'd0) ? 32'd0 : a / b;
    return a * b;
  endfunction

  function automatic logic [31:0] log_f(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    case (op)
      2'b00: return a & b;
      2'b01: return a | b;
      2'b10: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mul2 <= 32'd0; m_mul5 <= 32'd0; m_alu6 <= 32'd0; m_mul7 <= 32'd0;
      m_mul10 <= 32'd0; m_log11 <= 32'd0; m_alu12 <= 32'd0; m_result <= 32'd0;
      m_done <= 1'b0;
    end else begin
      if (reg_mul2_en)  m_mul2  <= mul_f(src(mul1_sel1), src(mul1_sel2), mul1_op);
      if (reg_mul5_en)  m_mul5  <= mul_f(src(mul1_sel1), src(mul1_sel2), mul1_op);
      if (reg_mul7_en)  m_mul7  <= mul_f(src(mul1_sel1), src(mul1_sel2), mul1_op);
      if (reg_mul10_en) m_mul10 <= mul_f(src(mul1_sel1), src(mul1_sel2), mul1_op);
      if (reg_alu6_en)  m_alu6  <= alu_f(src(alu1_sel1), src(alu1_sel2), alu1_op);
      if (reg_alu12_en) m_alu12 <= alu_f(src(alu1_sel1), src(alu1_sel2), alu1_op);
      if (reg_log11_en) m_log11 <= log_f(src(log1_sel1), src(log1_sel2), log1_op);
      if (result_en)    m_result <= m_alu12;
      m_done <= done_next;
    end
  end

  // Expected control outputs per step
  typedef struct {
    logic [3:0] a1s1, a1s2, m1s1, m1s2, l1s1, l1s2;
    logic       a_op, m_op;
    logic [1:0] l_op;
    logic [6:0] en;    // mul2, mul5, alu6, mul7, mul10, log11, alu12
    logic       res_en, dn, rdy, bsy;
  } dec_t;

  dec_t        tbl [8];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          exp_step = 0;
  int          n_done = 0;
  logic [31:0] exp_q [$];

  function automatic logic [31:0] ref_result();
    logic [31:0] r;
    r = (i1 * i2 + i3 * i4) * (i5 * i6);
    r = r ^ i1;
    return r - i2;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_decode(input string nm, input int s);
    logic [63:0] act, exp;
    dec_t d;
    d = tbl[s];
    act = {22'd0, alu1_sel1, alu1_sel2, mul1_sel1, mul1_sel2, log1_sel1, log1_sel2,
           alu1_op, mul1_op, log1_op,
           reg_mul2_en, reg_mul5_en, reg_alu6_en, reg_mul7_en, reg_mul10_en, reg_log11_en, reg_alu12_en,
           result_en, done_next, ready, busy, step};
    exp = {22'd0, d.a1s1, d.a1s2, d.m1s1, d.m1s2, d.l1s1, d.l1s2, d.a_op, d.m_op, d.l_op,
           d.en, d.res_en, d.dn, d.rdy, d.bsy, 3'(s)};
    chk(nm, act, exp);
  endtask

  task automatic set_ops(input logic [31:0] a, b, c, d, e, f);
    i1 = a; i2 = b; i3 = c; i4 = d; i5 = e; i6 = f;
  endtask

  // One clock: drive start, advance the reference step, check decode, done and result.
  task automatic cycle(input logic s, input logic new_ops);
    int prev;
    start = s;
    if ((exp_step == 0 || exp_step == 7) && s) begin
      if (new_ops) begin
        if ($urandom_range(0, 3) == 0)
          set_ops($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        else
          set_ops($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      end
      exp_q.push_back(ref_result());
    end
    @(posedge clk);
    prev = exp_step;
    if (prev == 0 || prev == 7) exp_step = s ? 1 : 0;
    else                        exp_step = prev + 1;
    @(negedge clk);
    check_decode("decode", exp_step);
    chk("done", {63'd0, m_done}, {63'd0, (prev == 7)});
    if (m_done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL result_q: done with no run pending at %0t", $time);
      end else begin
        chk("result", {32'd0, m_result}, {32'd0, exp_q.pop_front()});
      end
    end
  endtask

  initial begin
    tbl[0] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 7'b0000000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 7'b1000000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{4'd0, 4'd0, 4'd2, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 7'b0100000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{4'd6, 4'd7, 4'd4, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 7'b0011000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{4'd0, 4'd0, 4'd8, 4'd9, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 7'b0000100, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd10, 4'd0, 1'b0, 1'b0, 2'b10, 7'b0000010, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{4'd11, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 2'b00, 7'b0000001, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 7'b0000000, 1'b1, 1'b1, 1'b1, 1'b1};

    rst = 1'b0; start = 1'b0;
    set_ops(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    check_decode("reset", 0);
    rst = 1'b1;
    cycle(1'b0, 1'b0);

    // Worked example with every intermediate checked
    set_ops(32'd3, 32'd4, 32'd5, 32'd6, 32'd2, 32'd7);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0); chk("ex_mul2", {32'd0, m_mul2}, 64'd12);
    cycle(1'b0, 1'b0); chk("ex_mul5", {32'd0, m_mul5}, 64'd30);
    cycle(1'b0, 1'b0); chk("ex_alu6", {32'd0, m_alu6}, 64'd42);
                       chk("ex_mul7", {32'd0, m_mul7}, 64'd14);
    cycle(1'b0, 1'b0); chk("ex_mul10", {32'd0, m_mul10}, 64'd588);
    cycle(1'b0, 1'b0); chk("ex_log11", {32'd0, m_log11}, 64'd591);
    cycle(1'b0, 1'b0); chk("ex_alu12", {32'd0, m_alu12}, 64'd587);
    cycle(1'b0, 1'b0); chk("ex_result", {32'd0, m_result}, 64'd587);
    cycle(1'b0, 1'b0);

    // Modulo-2^32 wrap
    set_ops(32'hFFFF_FFFF, 32'd1, 32'd1, 32'd1, 32'd9, 32'd9);
    cycle(1'b1, 1'b0);
    for (int k = 0; k < 7; k++) cycle(1'b0, 1'b0);
    chk("wrap_alu6", {32'd0, m_alu6}, 64'd0);
    chk("wrap_mul10", {32'd0, m_mul10}, 64'd0);
    chk("wrap_log11", {32'd0, m_log11}, 64'h0000_0000_FFFF_FFFF);
    chk("wrap_result", {32'd0, m_result}, 64'h0000_0000_FFFF_FFFE);
    cycle(1'b0, 1'b0);

    // start held high: back-to-back runs, one done every 7 cycles
    n_done = 0;
    for (int k = 0; k < 22; k++) cycle(1'b1, 1'b1);
    chk("hold_dones", 64'(n_done), 64'd3);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0);

    // start pulsed during S3 is ignored
    n_done = 0;
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b0); cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0);
    chk("s3_dones", 64'(n_done), 64'd1);
    chk("s3_idle", {61'd0, step}, 64'd0);

    // Async reset mid-S4 drops all controls immediately
    cycle(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0);
    #2 rst = 1'b0;
    #1 check_decode("rst_mid_s4", 0);
    exp_step = 0;
    exp_q.delete();
    #1 rst = 1'b1;
    @(negedge clk);
    check_decode("rst_release", 0);
    n_done = 0;
    cycle(1'b1, 1'b1);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0);
    chk("post_rst_dones", 64'(n_done), 64'd1);

    // Randomized start pattern and operands
    for (int k = 0; k < 400; k++) cycle(($urandom_range(0, 2) != 0), 1'b1);
    for (int k = 0; k < 9; k++) cycle(1'b0, 1'b0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
